// File: rtl/servo_pwm_drv_pkg.sv
// Shared servo timing constants and types for the control-word path and the PWM stage.
// Upstream truncation logic imports the same CW so both stages agree on the word width.
package servo_pwm_drv_pkg;

    localparam int unsigned DEF_CW         = 8;
    localparam int unsigned DEF_CNT_W      = 21;
    localparam int unsigned DEF_PERIOD_CNT = 2_000_000;
    localparam int unsigned DEF_CENTER_CNT = 150_000;
    localparam int unsigned DEF_STEP_CNT   = 390;
    localparam int unsigned DEF_MIN_CNT    = 100_000;
    localparam int unsigned DEF_MAX_CNT    = 200_000;

    typedef enum logic {
        S_LOW  = 1'b0,
        S_HIGH = 1'b1
    } pwm_state_t;

endpackage

// File: rtl/servo_pwm_drv_if.sv
// Control-word input and servo output bundle between the IPD chain and the PWM driver.
interface servo_pwm_drv_if
    import servo_pwm_drv_pkg::*;
#(
    parameter int unsigned CW    = DEF_CW,
    parameter int unsigned CNT_W = DEF_CNT_W
);
    logic signed [CW-1:0]    trunc;
    logic                    valid;
    logic                    en;
    logic                    pwm;
    logic                    sample_req;
    logic                    sat;
    logic        [CNT_W-1:0] width_q;

    modport master (
        output trunc, valid, en,
        input  pwm, sample_req, sat, width_q
    );

    modport slave (
        input  trunc, valid, en,
        output pwm, sample_req, sat, width_q
    );
endinterface

// File: rtl/servo_width_map.sv
// Stage 1: maps the signed control word to a clamped pulse width and loads the shadow register.
module servo_width_map
    import servo_pwm_drv_pkg::*;
#(
    parameter int unsigned CW         = DEF_CW,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned CENTER_CNT = DEF_CENTER_CNT,
    parameter int unsigned STEP_CNT   = DEF_STEP_CNT,
    parameter int unsigned MIN_CNT    = DEF_MIN_CNT,
    parameter int unsigned MAX_CNT    = DEF_MAX_CNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [CW-1:0] trunc,
    input  logic                 valid,
    output logic     [CNT_W-1:0] shadow,
    output logic                 shadow_sat
);
    localparam logic signed [CNT_W:0] CENTER_S = (CNT_W+1)'(CENTER_CNT);
    localparam logic signed [CNT_W:0] STEP_S   = (CNT_W+1)'(STEP_CNT);
    localparam logic signed [CNT_W:0] MIN_S    = (CNT_W+1)'(MIN_CNT);
    localparam logic signed [CNT_W:0] MAX_S    = (CNT_W+1)'(MAX_CNT);

    logic signed [CNT_W:0]   trunc_x;
    logic signed [CNT_W:0]   calc;
    logic        [CNT_W-1:0] clamped;
    logic                    clip;

    // One extra bit keeps the negative side representable before the clamp.
    assign trunc_x = {{(CNT_W+1-CW){trunc[CW-1]}}, trunc};
    assign calc    = CENTER_S + trunc_x * STEP_S;

    always_comb begin
        clamped = calc[CNT_W-1:0];
        clip    = 1'b0;
        if (calc < MIN_S) begin
            clamped = MIN_S[CNT_W-1:0];
            clip    = 1'b1;
        end else if (calc > MAX_S) begin
            clamped = MAX_S[CNT_W-1:0];
            clip    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow     <= CNT_W'(CENTER_CNT);
            shadow_sat <= 1'b0;
        end else if (valid) begin
            shadow     <= clamped;
            shadow_sat <= clip;
        end
    end
endmodule

// File: rtl/servo_pwm_drv.sv
// Servo PWM driver: frame counter, frame-aligned width register, pulse FSM and sample request.
module servo_pwm_drv
    import servo_pwm_drv_pkg::*;
#(
    parameter int unsigned CW         = DEF_CW,
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned PERIOD_CNT = DEF_PERIOD_CNT,
    parameter int unsigned CENTER_CNT = DEF_CENTER_CNT,
    parameter int unsigned STEP_CNT   = DEF_STEP_CNT,
    parameter int unsigned MIN_CNT    = DEF_MIN_CNT,
    parameter int unsigned MAX_CNT    = DEF_MAX_CNT
) (
    input  logic            clk,
    input  logic            rst,
    servo_pwm_drv_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CNT - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PERIOD_CNT - 2);
    localparam logic [CNT_W-1:0] CENTER_W = CNT_W'(CENTER_CNT);

    if (!(MIN_CNT <= CENTER_CNT && CENTER_CNT <= MAX_CNT && MAX_CNT < PERIOD_CNT &&
          PERIOD_CNT < (64'd1 << CNT_W) && MIN_CNT > 0)) begin : g_bad_params
        $error("servo_pwm_drv: illegal timing parameters");
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active;
    logic [CNT_W-1:0] shadow;
    logic             shadow_sat;
    logic             boundary;
    pwm_state_t       state, state_nx;

    servo_width_map #(
        .CW         (CW),
        .CNT_W      (CNT_W),
        .CENTER_CNT (CENTER_CNT),
        .STEP_CNT   (STEP_CNT),
        .MIN_CNT    (MIN_CNT),
        .MAX_CNT    (MAX_CNT)
    ) u_map (
        .clk        (clk),
        .rst        (rst),
        .trunc      (bus.trunc),
        .valid      (bus.valid),
        .shadow     (shadow),
        .shadow_sat (shadow_sat)
    );

    assign boundary    = (cnt == LAST_CNT);
    assign bus.width_q = active;

    // State mirrors cnt<active for the current cycle; LOW only re-arms on the wrap to cnt==0.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_HIGH: if (cnt >= active) state_nx = S_LOW;
            S_LOW:  if (cnt == '0)     state_nx = S_HIGH;
            default: state_nx = S_LOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt            <= '0;
            active         <= CENTER_W;
            bus.sat        <= 1'b0;
            bus.pwm        <= 1'b0;
            bus.sample_req <= 1'b0;
            state          <= S_LOW;
        end else begin
            state          <= state_nx;
            bus.pwm        <= bus.en && (state_nx == S_HIGH);
            bus.sample_req <= (cnt == PRE_LAST);
            if (boundary) begin
                cnt     <= '0;
                active  <= shadow;
                bus.sat <= shadow_sat;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_servo_pwm_drv.sv
// Scoreboard bench for servo_pwm_drv: per-frame expected pulse width/sat/enable from a frame-level model.
module tb_servo_pwm_drv;
    localparam int PERIOD = 200;
    localparam int CENTER = 60;
    localparam int STEP   = 1;
    localparam int MINW   = 20;
    localparam int MAXW   = 100;

    typedef struct { int width; bit sat; bit en; } exp_t;
    typedef struct { int pos; logic signed [7:0] val; } ev_t;

    logic clk = 1'b0;
    logic rst;
    bit   mon_run = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    exp_t exp_q[$];
    ev_t  ev_q[$];

    int shadow_w, cur_w;
    bit shadow_s, cur_s;

    servo_pwm_drv_if #(.CW(8), .CNT_W(9)) bus ();

    servo_pwm_drv #(
        .CW         (8),
        .CNT_W      (9),
        .PERIOD_CNT (PERIOD),
        .CENTER_CNT (CENTER),
        .STEP_CNT   (STEP),
        .MIN_CNT    (MINW),
        .MAX_CNT    (MAXW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Pulse width = centre + word*step, clamped into [MIN,MAX].
    function automatic void ref_map(input int t, output int w, output bit s);
        w = CENTER + t * STEP;
        s = 1'b0;
        if (w < MINW) begin
            w = MINW;
            s = 1'b1;
        end else if (w > MAXW) begin
            w = MAXW;
            s = 1'b1;
        end
    endfunction

    task automatic add_ev(input int pos, input int val);
        ev_t e;
        e.pos = pos;
        e.val = val[7:0];
        ev_q.push_back(e);
    endtask

    // Entered at the start of a frame's first cycle; leaves at the start of the next frame.
    task automatic do_frame(input bit en_f);
        exp_t e;
        logic signed [7:0] v;
        bit fire;
        bus.en  = en_f;
        e.width = cur_w;
        e.sat   = cur_s;
        e.en    = en_f;
        exp_q.push_back(e);
        for (int p = 0; p < PERIOD; p++) begin
            fire = 1'b0;
            v    = '0;
            foreach (ev_q[i]) if (ev_q[i].pos == p) begin
                fire = 1'b1;
                v    = ev_q[i].val;
            end
            bus.valid = fire;
            if (fire) bus.trunc = v;
            if (p == PERIOD - 1) begin
                cur_w = shadow_w;
                cur_s = shadow_s;
            end
            if (fire) ref_map(int'(v), shadow_w, shadow_s);
            @(posedge clk);
            #1;
        end
        bus.valid = 1'b0;
        ev_q.delete();
    endtask

    task automatic model_reset();
        shadow_w = CENTER;
        shadow_s = 1'b0;
        cur_w    = CENTER;
        cur_s    = 1'b0;
    endtask

    initial begin : monitor
        int hi, cyc, last;
        bit has_prev;
        exp_t e;
        hi = 0; cyc = 0; last = 0; has_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!mon_run) begin
                hi       = 0;
                has_prev = 1'b0;
            end else begin
                if (bus.pwm) hi++;
                if (bus.sample_req) begin
                    if (has_prev) chk("sample_req_spacing", cyc - last, PERIOD);
                    has_prev = 1'b1;
                    last     = cyc;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pwm_high_count", hi, e.en ? e.width : 0);
                        chk("width_q", int'(bus.width_q), e.width);
                        chk("sat", int'(bus.sat), int'(e.sat));
                    end
                    hi = 0;
                end
            end
        end
    end

    initial begin : stimulus
        bus.trunc = '0;
        bus.valid = 1'b0;
        bus.en    = 1'b1;
        rst       = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1;
        chk("reset_pwm", int'(bus.pwm), 0);
        chk("reset_sample_req", int'(bus.sample_req), 0);
        chk("reset_sat", int'(bus.sat), 0);
        chk("reset_width_q", int'(bus.width_q), CENTER);
        rst     = 1'b1;
        mon_run = 1'b1;

        do_frame(1'b1);
        do_frame(1'b1);
        add_ev(40, 10);   do_frame(1'b1);
        add_ev(100, 127); do_frame(1'b1);
        add_ev(10, -128); do_frame(1'b1);
        add_ev(150, 0);   do_frame(1'b1);
        add_ev(PERIOD - 1, 5); do_frame(1'b1);
        do_frame(1'b1);
        add_ev(50, 20); add_ev(51, -20); do_frame(1'b1);
        do_frame(1'b0);
        do_frame(1'b0);
        do_frame(1'b1);

        add_ev(40, 10); do_frame(1'b1);
        mon_run = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("pre_reset_pwm", int'(bus.pwm), 1);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midreset_pwm", int'(bus.pwm), 0);
        chk("midreset_width_q", int'(bus.width_q), CENTER);
        chk("midreset_sample_req", int'(bus.sample_req), 0);
        chk("midreset_sat", int'(bus.sat), 0);
        exp_q.delete();
        model_reset();
        rst     = 1'b1;
        mon_run = 1'b1;
        do_frame(1'b1);

        for (int f = 0; f < 20; f++) begin
            int n;
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++)
                add_ev($urandom_range(0, PERIOD - 1), int'($urandom_range(0, 255)) - 128);
            do_frame($urandom_range(0, 4) != 0);
        end

        chk("frames_outstanding", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
